sample_tick_gen: RTL and testbench
==================================

Name: sample_tick_gen

Overview:
- Parametrised successor to the fixed 50 MHz → ~44.1 kHz divider.
- Generates exact-average sample-rate enable pulses from the system clock using a fractional (Bresenham) accumulator, so long-term rate is exact rather than rounded.
- Adds runtime rate selection (4 rates), an oversampled tick for per-sample pipelines, a wrapping sample counter, and glitch-free rate switching.
- Sits at the top of the synth datapath; every oscillator, envelope and DAC block qualifies on its ticks.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- OS, 4, oversample factor: tick_os pulses per tick; must be ≥1.
- ACC_W, 27, accumulator width; must satisfy 2^ACC_W > 2*CLK_HZ.
- CNT_W, 16, sample_cnt width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run enable; low freezes all state.
- resync  in  1  synchronous phase restart, single-cycle pulse.
- rate_sel  in  2  requested rate: 00=44100, 01=48000, 10=96000, 11=22050 Hz.
- tick  out  1  one-cycle pulse at sample rate.
- tick_os  out  1  one-cycle pulse at OS × sample rate.
- sample_cnt  out  CNT_W  count of ticks since reset/resync; wraps to 0.
- active_sel  out  2  rate currently in effect.
- rate_switched  out  1  one-cycle pulse when a new rate takes effect.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Priority each edge: reset > resync > en.
- Reset values: acc=0, os_cnt=0, tick=0, tick_os=0, sample_cnt=0, active_sel=00, rate_switched=0.
- Increment: inc = rate(active_sel) × OS.
- Every en=1 edge, sum = acc + inc:
  - sum ≥ CLK_HZ: acc ← sum − CLK_HZ, and tick_os ← 1.
  - Otherwise: acc ← sum, and tick_os ← 0.
- Output timing: all outputs are registered. A pulse is high for exactly the cycle following the edge that produced it.
- os_cnt: counts tick_os events 0..OS−1.
- tick: tick ← 1 on the same edge as the tick_os whose os_cnt == OS−1; os_cnt then wraps to 0. tick is always coincident with a tick_os.
- sample_cnt: increments on each tick edge and wraps 2^CNT_W−1 → 0.
- Exactness: over any window of N enabled cycles with N × inc divisible by CLK_HZ, tick_os count = N × inc / CLK_HZ exactly. No drift.
- en=0: acc, os_cnt and sample_cnt hold; tick, tick_os and rate_switched are 0. Resuming continues phase with no extra or lost pulse.
- Rate switching:
  - rate_sel is sampled every edge.
  - If en=1 and rate_sel ≠ active_sel, the change is held pending and applied only on an edge that asserts tick.
  - On that edge: active_sel ← rate_sel, rate_switched ← 1, acc is kept (phase-continuous).
  - The new inc takes effect on the following edge.
  - If rate_sel changes again before the boundary, the latest value wins.
  - If rate_sel returns to active_sel before the boundary, nothing is applied and there is no pulse.
- en=0 with rate_sel ≠ active_sel: applied on the next edge, with a rate_switched pulse.
- resync: acc, os_cnt and sample_cnt ← 0; active_sel ← rate_sel; all pulse outputs 0 that cycle; rate_switched 0.
- Reset mid-operation: returns to reset values on that edge; no pulse is emitted on the reset edge.
- Elaboration check: OS × 96000 ≤ CLK_HZ/2 and 2^ACC_W > 2*CLK_HZ; fail otherwise.

Decomposition:
- Package audio_clk_pkg:
  - rate_sel_e enum (RATE_44K1, RATE_48K, RATE_96K, RATE_22K05);
  - RATE_HZ constants;
  - function rate_hz(rate_sel_e).
- Sub-module frac_accum (params CLK_HZ, ACC_W):
  - inputs clk, reset, clear, en, inc;
  - output wrap pulse.
  - sample_tick_gen instantiates one frac_accum and adds os_cnt, sample_cnt and switch logic.

Test Plan:
1. Reset, en=1, rate_sel=00, OS=4 → tick_os first high after the 284th enabled edge; first tick after the 1134th enabled edge; sample_cnt=1 thereafter.
2. rate_sel=01, en=1 for 500,000 cycles from reset → exactly 1920 tick_os, 480 tick; acc=0 at end.
3. rate_sel 00→10 mid-sample → active_sel unchanged until next tick edge; rate_switched coincides with that tick; subsequent tick spacing ≈521 cycles.
4. en low for 1000 cycles mid-sample, then high → tick/tick_os stay 0 while low; total ticks equal an unpaused run shifted by 1000 cycles.
5. resync pulse and reset pulse, each mid-run → acc, os_cnt and sample_cnt cleared on that edge; no pulse that cycle; first tick again 1134 enabled edges later at 44.1 kHz.
6. sample_cnt wrap with CNT_W=4 → 15 → 0 on the 16th tick; no other effect.

Source files
------------

// File: rtl/sample_tick_gen_pkg.sv
// ---------------------------------------------------------------------------
// audio_clk_pkg
//   Shared definitions for the audio sample-rate tick generator.
//   - rate_sel_e : encoding of the runtime rate select (2 bits)
//   - RATE_HZ_*  : the four supported sample rates in Hz
//   - rate_hz()  : maps a rate select code to its rate in Hz
// ---------------------------------------------------------------------------
package audio_clk_pkg;

  typedef enum logic [1:0] {
    RATE_44K1  = 2'b00,
    RATE_48K   = 2'b01,
    RATE_96K   = 2'b10,
    RATE_22K05 = 2'b11
  } rate_sel_e;

  localparam int unsigned RATE_HZ_44K1  = 44_100;
  localparam int unsigned RATE_HZ_48K   = 48_000;
  localparam int unsigned RATE_HZ_96K   = 96_000;
  localparam int unsigned RATE_HZ_22K05 = 22_050;

  // Highest selectable rate; bounds the accumulator increment.
  localparam int unsigned RATE_HZ_MAX   = RATE_HZ_96K;

  function automatic int unsigned rate_hz(input rate_sel_e sel);
    int unsigned hz;
    case (sel)
      RATE_44K1:  hz = RATE_HZ_44K1;
      RATE_48K:   hz = RATE_HZ_48K;
      RATE_96K:   hz = RATE_HZ_96K;
      RATE_22K05: hz = RATE_HZ_22K05;
      default:    hz = RATE_HZ_44K1;
    endcase
    return hz;
  endfunction

endpackage

// File: rtl/sample_tick_gen_if.sv
// ---------------------------------------------------------------------------
// sample_tick_gen_if
//   Control and tick bundle of the sample-rate tick generator.
//   Controls (into the generator):
//     en            run enable; low freezes all state
//     resync        single-cycle synchronous phase restart
//     rate_sel      requested rate (00=44.1k, 01=48k, 10=96k, 11=22.05k)
//   Status (out of the generator):
//     tick          one-cycle pulse at the sample rate
//     tick_os       one-cycle pulse at OS x the sample rate
//     sample_cnt    wrapping count of ticks since reset/resync
//     active_sel    rate currently in effect
//     rate_switched one-cycle pulse when a new rate takes effect
//   Modports: master = the generator, slave = the consumer/controller.
// ---------------------------------------------------------------------------
interface sample_tick_gen_if #(
  parameter int unsigned CNT_W = 16
);

  logic             en;
  logic             resync;
  logic [1:0]       rate_sel;
  logic             tick;
  logic             tick_os;
  logic [CNT_W-1:0] sample_cnt;
  logic [1:0]       active_sel;
  logic             rate_switched;

  modport master (
    input  en,
    input  resync,
    input  rate_sel,
    output tick,
    output tick_os,
    output sample_cnt,
    output active_sel,
    output rate_switched
  );

  modport slave (
    output en,
    output resync,
    output rate_sel,
    input  tick,
    input  tick_os,
    input  sample_cnt,
    input  active_sel,
    input  rate_switched
  );

endinterface

// File: rtl/sample_tick_gen_frac_accum.sv
// ---------------------------------------------------------------------------
// frac_accum
//   Fractional (Bresenham) phase accumulator. Each enabled cycle adds inc to
//   the phase; whenever the sum reaches CLK_HZ the modulus is subtracted and
//   a wrap is produced. Because the remainder is carried, the long-term wrap
//   rate is exactly inc / CLK_HZ per cycle with no rounding drift.
//   Ports:
//     clk, reset  system clock, synchronous active-high reset
//     clear       synchronous phase restart (lower priority than reset)
//     en          advance enable; low holds the phase
//     inc         per-cycle phase increment (must be <= CLK_HZ/2)
//     wrap        registered one-cycle pulse, high the cycle after a wrap
//     wrap_now    combinational "this edge wraps" strobe, so the parent can
//                 register coincident pulses on the same edge as wrap
// ---------------------------------------------------------------------------
module frac_accum #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned ACC_W  = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic             wrap,
  output logic             wrap_now
);

  // One extra bit so acc + inc never overflows before the compare.
  localparam logic [ACC_W:0] MODULUS = (ACC_W + 1)'(CLK_HZ);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   sum;
  logic             wrap_reg;

  always_comb begin
    sum      = {1'b0, acc_reg} + {1'b0, inc};
    wrap_now = en & (sum >= MODULUS);
    acc_next = acc_reg;
    if (en) begin
      // acc < CLK_HZ and inc <= CLK_HZ/2, so a single subtraction suffices.
      acc_next = wrap_now ? ACC_W'(sum - MODULUS) : sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg  <= '0;
      wrap_reg <= 1'b0;
    end else if (clear) begin
      acc_reg  <= '0;
      wrap_reg <= 1'b0;
    end else begin
      acc_reg  <= acc_next;
      wrap_reg <= wrap_now;
    end
  end

  assign wrap = wrap_reg;

endmodule

// File: rtl/sample_tick_gen.sv
// ---------------------------------------------------------------------------
// sample_tick_gen
//   Exact-average sample-rate enable generator for the synth datapath.
//   A fractional accumulator advancing by rate x OS per clock yields tick_os;
//   every OS-th tick_os is also a tick. Adds a wrapping sample counter and
//   phase-continuous rate switching that only lands on a tick boundary.
//   Ports:
//     clk    system clock (CLK_HZ)
//     reset  synchronous, active-high reset
//     bus    sample_tick_gen_if.master: en, resync, rate_sel in;
//            tick, tick_os, sample_cnt, active_sel, rate_switched out
//   All outputs are registered; pulses are high for the cycle following the
//   edge that produced them. Edge priority: reset > resync > en.
// ---------------------------------------------------------------------------
module sample_tick_gen
  import audio_clk_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned OS     = 4,
  parameter int unsigned ACC_W  = 27,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  sample_tick_gen_if.master bus
);

  localparam int unsigned    OS_W    = (OS > 1) ? $clog2(OS) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS - 1);

  // -------------------------------------------------------------------------
  // Elaboration-time sanity checks on the parameter set.
  // -------------------------------------------------------------------------
  if ((OS < 1) || ((64'(OS) * 64'(RATE_HZ_MAX)) > (64'(CLK_HZ) / 64'd2))) begin : g_bad_os
    $error("sample_tick_gen: OS must be >= 1 and OS*96000 <= CLK_HZ/2");
  end

  if ((64'd1 << ACC_W) <= (64'd2 * 64'(CLK_HZ))) begin : g_bad_acc_w
    $error("sample_tick_gen: ACC_W too small, need 2^ACC_W > 2*CLK_HZ");
  end

  // -------------------------------------------------------------------------
  // Per-rate increments, folded to constants at elaboration.
  // -------------------------------------------------------------------------
  logic [ACC_W-1:0] inc_table [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_inc
    localparam logic [ACC_W-1:0] INC =
      ACC_W'(64'(rate_hz(rate_sel_e'(2'(gi)))) * 64'(OS));
    assign inc_table[gi] = INC;
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [OS_W-1:0]  os_cnt_reg;
  logic [OS_W-1:0]  os_cnt_next;
  logic [CNT_W-1:0] sample_cnt_reg;
  logic [CNT_W-1:0] sample_cnt_next;
  logic [1:0]       active_sel_reg;
  logic [1:0]       active_sel_next;
  logic             tick_reg;
  logic             rate_switched_reg;

  logic [ACC_W-1:0] inc;
  logic             wrap_now;
  logic             accum_wrap;
  logic             os_last;
  logic             tick_now;
  logic             switch_req;
  logic             switch_now;

  // Increment follows the registered active rate, so a rate applied on a
  // tick edge only changes the step from the following edge onwards.
  assign inc = inc_table[active_sel_reg];

  frac_accum #(
    .CLK_HZ (CLK_HZ),
    .ACC_W  (ACC_W)
  ) u_accum (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.resync),
    .en       (bus.en),
    .inc      (inc),
    .wrap     (accum_wrap),
    .wrap_now (wrap_now)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    os_last         = (os_cnt_reg == OS_LAST);
    tick_now        = wrap_now & os_last;

    os_cnt_next     = os_cnt_reg;
    if (wrap_now) begin
      os_cnt_next = os_last ? '0 : os_cnt_reg + 1'b1;
    end

    sample_cnt_next = tick_now ? sample_cnt_reg + 1'b1 : sample_cnt_reg;

    // A differing request is held off while running and lands only on a
    // tick edge; while stopped there is no phase to protect, so it lands at
    // once. Evaluating the live rate_sel at that edge gives "latest wins"
    // and drops a request that has returned to the active rate.
    switch_req      = (bus.rate_sel != active_sel_reg);
    switch_now      = switch_req & (~bus.en | tick_now);
    active_sel_next = switch_now ? bus.rate_sel : active_sel_reg;
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      os_cnt_reg        <= '0;
      sample_cnt_reg    <= '0;
      active_sel_reg    <= 2'b00;
      tick_reg          <= 1'b0;
      rate_switched_reg <= 1'b0;
    end else if (bus.resync) begin
      // Restart phase at the requested rate without a switch pulse.
      os_cnt_reg        <= '0;
      sample_cnt_reg    <= '0;
      active_sel_reg    <= bus.rate_sel;
      tick_reg          <= 1'b0;
      rate_switched_reg <= 1'b0;
    end else begin
      os_cnt_reg        <= os_cnt_next;
      sample_cnt_reg    <= sample_cnt_next;
      active_sel_reg    <= active_sel_next;
      tick_reg          <= tick_now;
      rate_switched_reg <= switch_now;
    end
  end

  assign bus.tick          = tick_reg;
  assign bus.tick_os       = accum_wrap;
  assign bus.sample_cnt    = sample_cnt_reg;
  assign bus.active_sel    = active_sel_reg;
  assign bus.rate_switched = rate_switched_reg;

endmodule

// File: tb/tb_sample_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_sample_tick_gen
//   Directed bench for sample_tick_gen at CLK_HZ=50 MHz, OS=4. A second
//   instance with CNT_W=4 shares all stimulus to exercise counter wrap.
// ---------------------------------------------------------------------------
module tb_sample_tick_gen;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sample_tick_gen_if #(.CNT_W(16)) bus ();
  sample_tick_gen_if #(.CNT_W(4))  bus4 ();

  assign bus4.en       = bus.en;
  assign bus4.resync   = bus.resync;
  assign bus4.rate_sel = bus.rate_sel;

  sample_tick_gen #(
    .CLK_HZ (50_000_000),
    .OS     (4),
    .ACC_W  (27),
    .CNT_W  (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sample_tick_gen #(
    .CLK_HZ (50_000_000),
    .OS     (4),
    .ACC_W  (27),
    .CNT_W  (4)
  ) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  int checks = 0;
  int errors = 0;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic run_until_tick(input int budget, output int edges,
                                output int os_seen, output bit found);
    edges   = 0;
    os_seen = 0;
    found   = 1'b0;
    while (!found && edges < budget) begin
      step();
      edges++;
      if (bus.tick_os === 1'b1) os_seen++;
      if (bus.tick === 1'b1) found = 1'b1;
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    bus.en = 1'b1; bus.resync = 1'b0; bus.rate_sel = 2'b00;
    reset = 1'b1;
    step();
    step();
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b, expected 0", bus.tick); end
    checks++; if (bus.tick_os !== 1'b0) begin errors++; $display("FAIL reset_tick_os: got %b, expected 0", bus.tick_os); end
    checks++; if (bus.sample_cnt !== 16'd0) begin errors++; $display("FAIL reset_sample_cnt: got %0d, expected 0", bus.sample_cnt); end
    checks++; if (bus.active_sel !== 2'b00) begin errors++; $display("FAIL reset_active_sel: got %b, expected 00", bus.active_sel); end
    checks++; if (bus.rate_switched !== 1'b0) begin errors++; $display("FAIL reset_rate_switched: got %b, expected 0", bus.rate_switched); end
    checks++; if (dut.u_accum.acc_reg !== 27'd0) begin errors++; $display("FAIL reset_acc: got %0d, expected 0", dut.u_accum.acc_reg); end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_first_tick();
    int   first_os   = 0;
    int   first_tick = 0;
    int   os_seen    = 0;
    logic os_at_tick = 1'b0;
    bus.en = 1'b1; bus.resync = 1'b0; bus.rate_sel = 2'b00;
    apply_reset();
    for (int e = 1; e <= 1200 && first_tick == 0; e++) begin
      step();
      if (bus.tick_os === 1'b1) begin
        os_seen++;
        if (first_os == 0) first_os = e;
      end
      if (bus.tick === 1'b1) begin
        first_tick = e;
        os_at_tick = bus.tick_os;
      end
    end
    checks++; if (first_os != 284) begin errors++; $display("FAIL first_tick_os_edge: got %0d, expected 284", first_os); end
    checks++; if (first_tick != 1134) begin errors++; $display("FAIL first_tick_edge: got %0d, expected 1134", first_tick); end
    checks++; if (os_seen != 4) begin errors++; $display("FAIL tick_os_per_tick: got %0d, expected 4", os_seen); end
    checks++; if (os_at_tick !== 1'b1) begin errors++; $display("FAIL tick_coincident_os: got %b, expected 1", os_at_tick); end
    step();
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL tick_one_cycle: got %b, expected 0", bus.tick); end
    checks++; if (bus.sample_cnt !== 16'd1) begin errors++; $display("FAIL first_sample_cnt: got %0d, expected 1", bus.sample_cnt); end
    $display("test_first_tick: tick_os at %0d, tick at %0d", first_os, first_tick);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_exact_rate();
    int os_seen = 0;
    int ticks   = 0;
    bus.en = 1'b1; bus.resync = 1'b0; bus.rate_sel = 2'b00;
    apply_reset();
    // Stopped: a differing rate applies on the next edge, with a pulse.
    bus.en = 1'b0; bus.rate_sel = 2'b01;
    step();
    checks++; if (bus.active_sel !== 2'b01) begin errors++; $display("FAIL idle_switch_sel: got %b, expected 01", bus.active_sel); end
    checks++; if (bus.rate_switched !== 1'b1) begin errors++; $display("FAIL idle_switch_pulse: got %b, expected 1", bus.rate_switched); end
    step();
    checks++; if (bus.rate_switched !== 1'b0) begin errors++; $display("FAIL idle_switch_one_cycle: got %b, expected 0", bus.rate_switched); end
    // 6250 cycles * 192000 / 50e6 = 24 tick_os exactly.
    bus.en = 1'b1;
    for (int e = 1; e <= 6250; e++) begin
      step();
      if (bus.tick_os === 1'b1) os_seen++;
      if (bus.tick === 1'b1) ticks++;
    end
    checks++; if (os_seen != 24) begin errors++; $display("FAIL exact_tick_os: got %0d, expected 24", os_seen); end
    checks++; if (ticks != 6) begin errors++; $display("FAIL exact_ticks: got %0d, expected 6", ticks); end
    checks++; if (dut.u_accum.acc_reg !== 27'd0) begin errors++; $display("FAIL exact_acc_zero: got %0d, expected 0", dut.u_accum.acc_reg); end
    checks++; if (bus.sample_cnt !== 16'd6) begin errors++; $display("FAIL exact_sample_cnt: got %0d, expected 6", bus.sample_cnt); end
    $display("test_exact_rate: %0d tick_os, %0d ticks", os_seen, ticks);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_switch_cancel();
    int   sw_seen   = 0;
    int   tick_edge = 0;
    bus.en = 1'b1; bus.resync = 1'b0; bus.rate_sel = 2'b00;
    apply_reset();
    for (int e = 1; e <= 1134; e++) begin
      if (e == 500) bus.rate_sel = 2'b01;
      if (e == 900) bus.rate_sel = 2'b00;
      step();
      if (bus.rate_switched === 1'b1) sw_seen++;
      if (bus.tick === 1'b1 && tick_edge == 0) tick_edge = e;
    end
    checks++; if (sw_seen != 0) begin errors++; $display("FAIL cancel_no_pulse: got %0d pulses, expected 0", sw_seen); end
    checks++; if (tick_edge != 1134) begin errors++; $display("FAIL cancel_tick_edge: got %0d, expected 1134", tick_edge); end
    checks++; if (bus.active_sel !== 2'b00) begin errors++; $display("FAIL cancel_active_sel: got %b, expected 00", bus.active_sel); end
    $display("test_switch_cancel: tick at %0d", tick_edge);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_switch_mid();
    int   early_bad = 0;
    logic tick_b, sw_b;
    logic [1:0] sel_b;
    int   gap     = 0;
    int   late_sw = 0;
    bit   found   = 1'b0;
    bus.en = 1'b1; bus.resync = 1'b0; bus.rate_sel = 2'b00;
    apply_reset();
    for (int e = 1; e < 2268; e++) begin
      if (e == 1234) bus.rate_sel = 2'b01;
      if (e == 1434) bus.rate_sel = 2'b10;
      step();
      if (bus.active_sel !== 2'b00 || bus.rate_switched !== 1'b0) early_bad++;
    end
    step();
    tick_b = bus.tick; sw_b = bus.rate_switched; sel_b = bus.active_sel;
    checks++; if (early_bad != 0) begin errors++; $display("FAIL switch_held: got %0d early changes, expected 0", early_bad); end
    checks++; if (tick_b !== 1'b1) begin errors++; $display("FAIL switch_boundary_tick: got %b, expected 1", tick_b); end
    checks++; if (sw_b !== 1'b1) begin errors++; $display("FAIL switch_pulse: got %b, expected 1", sw_b); end
    checks++; if (sel_b !== 2'b10) begin errors++; $display("FAIL switch_latest_sel: got %b, expected 10", sel_b); end
    // acc=75200 after the boundary; 4 wraps at inc 384000 need 521 edges.
    while (!found && gap < 700) begin
      step();
      gap++;
      if (bus.rate_switched === 1'b1) late_sw++;
      if (bus.tick === 1'b1) found = 1'b1;
    end
    checks++; if (gap != 521) begin errors++; $display("FAIL switch_new_spacing: got %0d, expected 521", gap); end
    checks++; if (late_sw != 0) begin errors++; $display("FAIL switch_single_pulse: got %0d extra, expected 0", late_sw); end
    $display("test_switch_mid: next tick after %0d edges", gap);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_pause();
    int os_seen = 0;
    int paused_pulses = 0;
    int edges;
    int os_after;
    bit found;
    bus.en = 1'b1; bus.resync = 1'b0; bus.rate_sel = 2'b00;
    apply_reset();
    for (int e = 1; e <= 600; e++) begin
      step();
      if (bus.tick_os === 1'b1) os_seen++;
    end
    checks++; if (os_seen != 2) begin errors++; $display("FAIL pause_pre_os: got %0d, expected 2", os_seen); end
    bus.en = 1'b0;
    for (int e = 1; e <= 1000; e++) begin
      step();
      if (bus.tick !== 1'b0 || bus.tick_os !== 1'b0) paused_pulses++;
    end
    checks++; if (paused_pulses != 0) begin errors++; $display("FAIL pause_quiet: got %0d pulses, expected 0", paused_pulses); end
    bus.en = 1'b1;
    run_until_tick(2000, edges, os_after, found);
    checks++; if (!found || edges != 534) begin errors++; $display("FAIL pause_resume_edge: got %0d, expected 534", edges); end
    checks++; if (os_after != 2) begin errors++; $display("FAIL pause_resume_os: got %0d, expected 2", os_after); end
    checks++; if (bus.sample_cnt !== 16'd1) begin errors++; $display("FAIL pause_sample_cnt: got %0d, expected 1", bus.sample_cnt); end
    $display("test_pause: tick %0d edges after resume", edges);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_resync();
    int edges;
    int os_seen;
    bit found;
    bus.en = 1'b1; bus.resync = 1'b0; bus.rate_sel = 2'b00;
    apply_reset();
    for (int e = 1; e <= 1417; e++) step();
    checks++; if (bus.sample_cnt !== 16'd1) begin errors++; $display("FAIL resync_pre_cnt: got %0d, expected 1", bus.sample_cnt); end
    // Edge 1418 would have produced the 5th tick_os; resync must suppress it.
    bus.resync = 1'b1;
    step();
    bus.resync = 1'b0;
    checks++; if (bus.tick_os !== 1'b0) begin errors++; $display("FAIL resync_no_os: got %b, expected 0", bus.tick_os); end
    checks++; if (bus.sample_cnt !== 16'd0) begin errors++; $display("FAIL resync_cnt: got %0d, expected 0", bus.sample_cnt); end
    checks++; if (dut.u_accum.acc_reg !== 27'd0) begin errors++; $display("FAIL resync_acc: got %0d, expected 0", dut.u_accum.acc_reg); end
    run_until_tick(2000, edges, os_seen, found);
    checks++; if (!found || edges != 1134) begin errors++; $display("FAIL resync_first_tick: got %0d, expected 1134", edges); end
    checks++; if (os_seen != 4) begin errors++; $display("FAIL resync_os_count: got %0d, expected 4", os_seen); end
    // Resync picks up a new rate directly, without a switch pulse.
    bus.rate_sel = 2'b11; bus.resync = 1'b1;
    step();
    bus.resync = 1'b0;
    checks++; if (bus.active_sel !== 2'b11) begin errors++; $display("FAIL resync_sel: got %b, expected 11", bus.active_sel); end
    checks++; if (bus.rate_switched !== 1'b0) begin errors++; $display("FAIL resync_no_switch_pulse: got %b, expected 0", bus.rate_switched); end
    run_until_tick(3000, edges, os_seen, found);
    checks++; if (!found || edges != 2268) begin errors++; $display("FAIL resync_22k_tick: got %0d, expected 2268", edges); end
    $display("test_resync: 22.05k tick after %0d edges", edges);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    int edges;
    int os_seen;
    bit found;
    for (int e = 1; e <= 700; e++) step();
    bus.rate_sel = 2'b00;
    reset = 1'b1;
    step();
    checks++; if (bus.tick_os !== 1'b0 || bus.tick !== 1'b0) begin errors++; $display("FAIL reset_mid_pulses: got tick_os=%b tick=%b, expected 0 0", bus.tick_os, bus.tick); end
    checks++; if (bus.active_sel !== 2'b00) begin errors++; $display("FAIL reset_mid_sel: got %b, expected 00", bus.active_sel); end
    checks++; if (dut.u_accum.acc_reg !== 27'd0) begin errors++; $display("FAIL reset_mid_acc: got %0d, expected 0", dut.u_accum.acc_reg); end
    checks++; if (bus.rate_switched !== 1'b0) begin errors++; $display("FAIL reset_mid_switch: got %b, expected 0", bus.rate_switched); end
    reset = 1'b0;
    run_until_tick(2000, edges, os_seen, found);
    checks++; if (!found || edges != 1134) begin errors++; $display("FAIL reset_mid_first_tick: got %0d, expected 1134", edges); end
    checks++; if (bus.sample_cnt !== 16'd1) begin errors++; $display("FAIL reset_mid_cnt: got %0d, expected 1", bus.sample_cnt); end
    $display("test_reset_mid: tick after %0d edges", edges);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_cnt_wrap();
    int edges;
    int os_seen;
    bit found;
    logic [3:0] exp4;
    bus.en = 1'b1; bus.resync = 1'b0; bus.rate_sel = 2'b00;
    apply_reset();
    bus.en = 1'b0; bus.rate_sel = 2'b10;
    step();
    bus.en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      run_until_tick(700, edges, os_seen, found);
      exp4 = 4'(i);
      if (i == 1) begin
        checks++; if (edges != 521) begin errors++; $display("FAIL wrap_first_96k_tick: got %0d, expected 521", edges); end
      end
      checks++; if (!found) begin errors++; $display("FAIL wrap_tick_timeout: tick %0d not seen, expected within 700", i); end
      checks++; if (bus4.tick !== 1'b1) begin errors++; $display("FAIL wrap_tick_coincident: got %b, expected 1", bus4.tick); end
      checks++; if (bus4.sample_cnt !== exp4) begin errors++; $display("FAIL wrap_cnt4: got %0d, expected %0d", bus4.sample_cnt, exp4); end
      checks++; if (bus.sample_cnt !== 16'(i)) begin errors++; $display("FAIL wrap_cnt16: got %0d, expected %0d", bus.sample_cnt, i); end
      $display("tick %0d: cnt16=%0d cnt4=%0d", i, bus.sample_cnt, bus4.sample_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.en = 1'b0; bus.resync = 1'b0; bus.rate_sel = 2'b00;
    test_reset();
    test_first_tick();
    test_exact_rate();
    test_switch_cancel();
    test_switch_mid();
    test_pause();
    test_resync();
    test_reset_mid();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
